// File: rtl/traffic_pkg.sv
// Shared types and lamp codes for the N-phase intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED,
    ST_GREEN,
    ST_YELLOW,
    ST_PREEMPT,
    ST_FLASH
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_arbiter.sv
// Round-robin demand search starting after the given phase, wrapping,
// with that phase itself searched last.
module phase_arbiter #(
  parameter int NUM_PHASES = 4,
  localparam int PW = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] demand,
  input  logic [PW-1:0]         active_phase,
  output logic [PW-1:0]         next_phase,
  output logic                  other_demand
);

  logic [PW-1:0] idx;

  always_comb begin
    next_phase   = active_phase;
    other_demand = 1'b0;
    idx          = '0;
    // Walk farthest-first so the nearest requester wins.
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = PW'((int'(active_phase) + k) % NUM_PHASES);
      if (demand[idx]) next_phase = idx;
    end
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (demand[i] && (PW'(i) != active_phase)) other_demand = 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-phase demand-actuated signal controller with preemption and flash.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int GREEN_T    = 7,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int FLASH_T    = 4,
  localparam int PW = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_PHASES-1:0]   demand,
  input  logic                    preempt_req,
  input  logic [PW-1:0]           preempt_phase,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PW-1:0]           active_phase,
  output logic                    preempt_ack
);

  localparam int TMAX = imax(imax(GREEN_T, YELLOW_T),
                             imax(ALLRED_T, FLASH_T));
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_T);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T);
  localparam logic [TW-1:0] T_FLASH  = TW'(FLASH_T);
  localparam logic [PW:0]   NP_W     = (PW+1)'(NUM_PHASES);

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [PW-1:0]           active_q, active_d;
  logic                    fresh_q, fresh_d;
  logic                    flash_red_q, flash_red_d;
  logic [3*NUM_PHASES-1:0] lights_q, lights_d;
  logic                    ack_q, ack_d;

  logic          pp_valid;
  logic          expire;
  logic [PW-1:0] arb_base;
  logic [PW-1:0] next_phase;
  logic          other_demand;

  // Until some phase has held green, the search begins at phase 0.
  assign arb_base = fresh_q ? PW'(NUM_PHASES - 1) : active_q;

  phase_arbiter #(
    .NUM_PHASES(NUM_PHASES)
  ) u_arb (
    .demand      (demand),
    .active_phase(arb_base),
    .next_phase  (next_phase),
    .other_demand(other_demand)
  );

  assign pp_valid = preempt_req &&
                    ({1'b0, preempt_phase} < NP_W);
  assign expire   = (timer_q <= TW'(1));

  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q != '0) ? timer_q - TW'(1) : '0;
    active_d    = active_q;
    fresh_d     = fresh_q;
    flash_red_d = flash_red_q;
    if (!en) begin
      state_d = ST_FLASH;
      if (state_q != ST_FLASH) begin
        timer_d     = T_FLASH;
        flash_red_d = 1'b1;
      end else if (expire) begin
        timer_d     = T_FLASH;
        flash_red_d = ~flash_red_q;
      end
    end else begin
      unique case (state_q)
        ST_FLASH: begin
          state_d = ST_ALLRED;
          timer_d = T_ALLRED;
        end
        ST_ALLRED: begin
          if (expire) begin
            fresh_d = 1'b0;
            if (pp_valid) begin
              state_d  = ST_PREEMPT;
              active_d = preempt_phase;
              timer_d  = '0;
            end else begin
              state_d = ST_GREEN;
              timer_d = T_GREEN;
              if (|demand) active_d = next_phase;
            end
          end
        end
        ST_GREEN: begin
          if (pp_valid && (preempt_phase != active_q)) begin
            state_d = ST_YELLOW;
            timer_d = T_YELLOW;
          end else if (pp_valid) begin
            state_d = ST_PREEMPT;
            timer_d = '0;
          end else if (expire && other_demand) begin
            state_d = ST_YELLOW;
            timer_d = T_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (expire) begin
            state_d = ST_ALLRED;
            timer_d = T_ALLRED;
          end
        end
        ST_PREEMPT: begin
          if (!preempt_req) begin
            state_d = ST_YELLOW;
            timer_d = T_YELLOW;
          end
        end
        default: begin
          state_d = ST_ALLRED;
          timer_d = T_ALLRED;
        end
      endcase
    end

    ack_d    = (state_d == ST_PREEMPT);
    lights_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      lights_d[3*i +: 3] = LAMP_RED;
      if (state_d == ST_FLASH) begin
        lights_d[3*i +: 3] = flash_red_d ? LAMP_RED : LAMP_OFF;
      end else if (PW'(i) == active_d) begin
        if (state_d == ST_GREEN || state_d == ST_PREEMPT)
          lights_d[3*i +: 3] = LAMP_GREEN;
        else if (state_d == ST_YELLOW)
          lights_d[3*i +: 3] = LAMP_YELLOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ALLRED;
      timer_q     <= T_ALLRED;
      active_q    <= '0;
      fresh_q     <= 1'b1;
      flash_red_q <= 1'b1;
      lights_q    <= {NUM_PHASES{LAMP_RED}};
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      active_q    <= active_d;
      fresh_q     <= fresh_d;
      flash_red_q <= flash_red_d;
      lights_q    <= lights_d;
      ack_q       <= ack_d;
    end
  end

  assign lights       = lights_q;
  assign active_phase = active_q;
  assign preempt_ack  = ack_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: behavioural intersection model predicts every cycle.
module tb_traffic_phase_controller;

  localparam int N  = 4;
  localparam int GT = 5;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int FT = 2;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;
  localparam logic [2:0] L_O = 3'b000;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   demand;
  logic           preempt_req;
  logic [1:0]     preempt_phase;
  logic [3*N-1:0] lights;
  logic [1:0]     active_phase;
  logic           preempt_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .NUM_PHASES(N),
    .GREEN_T   (GT),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT),
    .FLASH_T   (FT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .demand       (demand),
    .preempt_req  (preempt_req),
    .preempt_phase(preempt_phase),
    .lights       (lights),
    .active_phase (active_phase),
    .preempt_ack  (preempt_ack)
  );

  typedef enum {M_CLR, M_GO, M_AMBER, M_EMERG, M_MAINT} mmode_t;

  typedef struct {
    logic [3*N-1:0] lights;
    logic [1:0]     phase;
    logic           ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mmode_t m_mode;
  int     m_age;
  int     m_owner;
  bit     m_lit;
  bit     m_fresh;

  function automatic void m_reset();
    m_mode  = M_CLR;
    m_age   = 0;
    m_owner = 0;
    m_fresh = 1'b1;
    m_lit   = 1'b1;
  endfunction

  function automatic void go(mmode_t md);
    m_mode = md;
    m_age  = 0;
  endfunction

  function automatic int rr();
    int start;
    int idx;
    start = m_fresh ? N - 1 : m_owner;
    for (int k = 1; k <= N; k++) begin
      idx = (start + k) % N;
      if (demand[2'(idx)]) return idx;
    end
    return m_owner;
  endfunction

  function automatic void model_edge();
    bit pv;
    bit others;
    pv     = preempt_req && (int'(preempt_phase) < N);
    others = (demand & ~(N'(1) << m_owner)) != 0;
    if (!en) begin
      if (m_mode != M_MAINT) begin
        go(M_MAINT);
        m_lit = 1'b1;
      end else begin
        m_age++;
        if (m_age == FT) begin
          m_age = 0;
          m_lit = !m_lit;
        end
      end
    end else begin
      case (m_mode)
        M_MAINT: go(M_CLR);
        M_CLR: begin
          if (m_age + 1 >= AT) begin
            if (pv) begin
              m_owner = int'(preempt_phase);
              go(M_EMERG);
            end else begin
              if (demand != 0) m_owner = rr();
              go(M_GO);
            end
            m_fresh = 1'b0;
          end else m_age++;
        end
        M_GO: begin
          if (pv && int'(preempt_phase) != m_owner) go(M_AMBER);
          else if (pv) go(M_EMERG);
          else if (m_age + 1 >= GT && others) go(M_AMBER);
          else m_age++;
        end
        M_AMBER: begin
          if (m_age + 1 >= YT) go(M_CLR);
          else m_age++;
        end
        M_EMERG: if (!preempt_req) go(M_AMBER);
        default: go(M_CLR);
      endcase
    end
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [2:0] c;
    e.lights = '0;
    for (int i = 0; i < N; i++) begin
      c = L_R;
      if (m_mode == M_MAINT) c = m_lit ? L_R : L_O;
      else if (i == m_owner) begin
        if (m_mode == M_GO || m_mode == M_EMERG) c = L_G;
        else if (m_mode == M_AMBER) c = L_Y;
      end
      e.lights[3*i +: 3] = c;
    end
    e.phase = 2'(m_owner);
    e.ack   = (m_mode == M_EMERG);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("lights", 32'(lights), 32'(mon_e.lights));
      chk("active_phase", 32'(active_phase), 32'(mon_e.phase));
      chk("preempt_ack", 32'(preempt_ack), 32'(mon_e.ack));
    end
  end

  task automatic tick();
    if (!rst) m_reset();
    else model_edge();
    @(posedge clk);
    #1;
    exp_q.push_back(expect_now());
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_lamp(int ph, logic [2:0] code, int limit,
                           string name);
    int n;
    n = 0;
    while (lights[3*ph +: 3] !== code && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (lights[3*ph +: 3] !== code) begin
      errors++;
      $display("FAIL %s: lamp %0d is %b, wanted %b within %0d cycles",
               name, ph, lights[3*ph +: 3], code, limit);
    end
  endtask

  initial begin
    rst           = 1'b0;
    en            = 1'b1;
    demand        = '0;
    preempt_req   = 1'b0;
    preempt_phase = '0;
    m_reset();
    ticks(3);
    rst = 1'b1;

    demand = 4'b1111;
    ticks(45);

    demand = 4'b0100;
    wait_lamp(2, L_G, 40, "rest_green_ph2");
    ticks(20);
    demand = 4'b0101;
    ticks(12);

    demand = 4'b1000;
    wait_lamp(3, L_G, 40, "green_ph3");
    demand = 4'b0001;
    ticks(12);

    demand = 4'b0010;
    wait_lamp(1, L_G, 40, "green_ph1");
    tick();
    preempt_req   = 1'b1;
    preempt_phase = 2'd3;
    ticks(14);
    preempt_req = 1'b0;
    ticks(10);

    wait_lamp(1, L_G, 40, "green_ph1_again");
    preempt_req   = 1'b1;
    preempt_phase = 2'd1;
    ticks(5);
    preempt_req = 1'b0;
    ticks(6);

    demand = 4'b1111;
    wait_lamp(0, L_Y, 60, "yellow_before_reset");
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_lights", 32'(lights), 32'({N{L_R}}));
    chk("async_reset_phase", 32'(active_phase), 32'd0);
    chk("async_reset_ack", 32'(preempt_ack), 32'd0);
    m_reset();
    ticks(3);
    rst = 1'b1;
    ticks(4);

    wait_lamp(0, L_G, 60, "green_ph0_flash");
    en = 1'b0;
    ticks(9);
    en = 1'b1;
    ticks(12);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) demand = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) preempt_req = ~preempt_req;
      if ($urandom_range(0, 9) == 0)
        preempt_phase = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) en = ~en;
      tick();
    end
    en          = 1'b1;
    preempt_req = 1'b0;
    ticks(4);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, wanted 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
